spectrum_peak_picker: RTL and testbench

Consumes a finished FFT frame through the FFT core's DMA read port. It computes the magnitude of each positive-frequency bin and keeps the strongest bin in each of six fixed frequency bands. It then emits the six peaks as a handshaked stream to the fingerprint hasher and pulses a restart so the FFT core captures the next frame. It sits directly downstream of the FFT core, between its DMA bus and the fingerprint logic.

---
 rtl/spectrum_peak_picker_pkg.sv | 20 ++
 rtl/spectrum_peak_picker_if.sv | 26 ++
 rtl/spectrum_peak_picker_tracker.sv | 43 ++++
 rtl/spectrum_peak_picker.sv | 144 ++++++++++++++
 tb/tb_spectrum_peak_picker.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/spectrum_peak_picker_pkg.sv
// spectrum_pkg: shared FSM states, band map and magnitude width for the spectrum peak picker.
package spectrum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_EMIT,
        ST_RESTART
    } state_e;

    localparam int NUM_BANDS = 6;
    localparam int DATA_W    = 16;
    localparam int MAG_W     = 2 * DATA_W;

    // Inclusive bin edges of the six analysis bands.
    localparam int BAND_LO [NUM_BANDS] = '{1, 11, 21, 41, 81, 161};
    localparam int BAND_HI [NUM_BANDS] = '{10, 20, 40, 80, 160, 511};

endpackage

// File: rtl/spectrum_peak_picker_if.sv
// spectrum_peak_picker_if: FFT DMA read port plus the peak stream towards the fingerprint hasher.
interface spectrum_peak_picker_if #(
    parameter int FFT_N      = 10,
    parameter int DATA_WIDTH = 16
);
    logic                         dmaact;
    logic [FFT_N-1:0]             dmaa;
    logic signed [DATA_WIDTH-1:0] dmadr_real;
    logic signed [DATA_WIDTH-1:0] dmadr_imag;
    logic                         peak_valid;
    logic                         peak_ready;
    logic [2:0]                   peak_band;
    logic [FFT_N-1:0]             peak_bin;
    logic [2*DATA_WIDTH-1:0]      peak_mag;
    logic signed [7:0]            peak_exp;

    modport master (
        output dmaact, dmaa, peak_valid, peak_band, peak_bin, peak_mag, peak_exp,
        input  dmadr_real, dmadr_imag, peak_ready
    );

    modport slave (
        input  dmaact, dmaa, peak_valid, peak_band, peak_bin, peak_mag, peak_exp,
        output dmadr_real, dmadr_imag, peak_ready
    );
endinterface

// File: rtl/spectrum_peak_picker_tracker.sv
// band_max_tracker: per-band running maximum (magnitude + bin) with clear, update and indexed read.
module band_max_tracker
    import spectrum_pkg::*;
#(
    parameter int AW = 10,
    parameter int MW = MAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          upd_i,
    input  logic [AW-1:0] bin_i,
    input  logic [MW-1:0] mag_i,
    input  logic [2:0]    sel_i,
    output logic [AW-1:0] bin_o,
    output logic [MW-1:0] mag_o
);
    logic [MW-1:0]        mag_q [NUM_BANDS];
    logic [AW-1:0]        bin_q [NUM_BANDS];
    logic [NUM_BANDS-1:0] hit;

    // Strictly greater replaces, so the lowest bin keeps a tie.
    always_comb begin
        hit = '0;
        for (int b = 0; b < NUM_BANDS; b++)
            hit[b] = upd_i && bin_i >= AW'(BAND_LO[b]) && bin_i <= AW'(BAND_HI[b]) && mag_i > mag_q[b];
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (rst || clr_i) begin
                mag_q[b] <= '0;
                bin_q[b] <= AW'(BAND_LO[b]);
            end else if (hit[b]) begin
                mag_q[b] <= mag_i;
                bin_q[b] <= bin_i;
            end
        end
    end

    assign bin_o = sel_i < 3'(NUM_BANDS) ? bin_q[sel_i] : '0;
    assign mag_o = sel_i < 3'(NUM_BANDS) ? mag_q[sel_i] : '0;
endmodule

// File: rtl/spectrum_peak_picker.sv
// spectrum_peak_picker: scans one FFT frame, keeps the strongest bin per band and streams six peaks.
// Define SPECTRUM_L1_MAG_EN to use |re|+|im| instead of re^2+im^2 (no multipliers).
module spectrum_peak_picker
    import spectrum_pkg::*;
#(
    parameter int FFT_N      = 10,
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_done,
    input  logic signed [7:0]     fft_bfpexp,
    output logic                  fft_restart,
    output logic [15:0]           frame_count,
    spectrum_peak_picker_if.master bus
);
    localparam int MW = 2 * DATA_WIDTH;
    localparam logic [FFT_N-1:0] LAST_BIN = FFT_N'((1 << (FFT_N - 1)) - 1);

    state_e            state_q;
    logic              act_q;
    logic [FFT_N-1:0]  addr_q;
    logic [1:0]        drain_q;
    logic [2:0]        band_q;
    logic              valid_q;
    logic              restart_q;
    logic signed [7:0] exp_q;
    logic [15:0]       frame_q;
    logic              v1_q, v2_q;
    logic [FFT_N-1:0]  a1_q, a2_q;
    logic [MW-1:0]     mag_q, mag_d;
    logic [FFT_N-1:0]  trk_bin;
    logic [MW-1:0]     trk_mag;
    logic              start;

`ifdef SPECTRUM_L1_MAG_EN
    logic signed [DATA_WIDTH:0] re_x, im_x;
    logic [DATA_WIDTH:0]        re_abs, im_abs;
    always_comb begin
        re_x   = {bus.dmadr_real[DATA_WIDTH-1], bus.dmadr_real};
        im_x   = {bus.dmadr_imag[DATA_WIDTH-1], bus.dmadr_imag};
        re_abs = re_x[DATA_WIDTH] ? $unsigned(-re_x) : $unsigned(re_x);
        im_abs = im_x[DATA_WIDTH] ? $unsigned(-im_x) : $unsigned(im_x);
        mag_d  = MW'(re_abs + im_abs);
    end
`else
    logic signed [MW-1:0] re_sq, im_sq;
    always_comb begin
        re_sq = MW'(bus.dmadr_real) * MW'(bus.dmadr_real);
        im_sq = MW'(bus.dmadr_imag) * MW'(bus.dmadr_imag);
        mag_d = $unsigned(re_sq) + $unsigned(im_sq);
    end
`endif

    assign start = state_q == ST_IDLE && fft_done;

    // Address at t, data at t+1, magnitude at t+2, band update at t+3.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            act_q     <= 1'b0;
            addr_q    <= '0;
            drain_q   <= '0;
            band_q    <= '0;
            valid_q   <= 1'b0;
            restart_q <= 1'b0;
            exp_q     <= '0;
            frame_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            a1_q      <= '0;
            a2_q      <= '0;
            mag_q     <= '0;
        end else begin
            v1_q  <= act_q;
            a1_q  <= addr_q;
            v2_q  <= v1_q;
            a2_q  <= a1_q;
            mag_q <= mag_d;
            case (state_q)
                ST_IDLE: if (fft_done) begin
                    exp_q   <= fft_bfpexp;
                    act_q   <= 1'b1;
                    addr_q  <= FFT_N'(1);
                    state_q <= ST_SCAN;
                end
                ST_SCAN: if (addr_q == LAST_BIN) begin
                    act_q   <= 1'b0;
                    addr_q  <= '0;
                    drain_q <= '0;
                    state_q <= ST_DRAIN;
                end else begin
                    addr_q <= addr_q + 1'b1;
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == 2'd1) begin
                        band_q  <= '0;
                        valid_q <= 1'b1;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: if (bus.peak_ready) begin
                    if (band_q == 3'(NUM_BANDS - 1)) begin
                        valid_q   <= 1'b0;
                        restart_q <= 1'b1;
                        frame_q   <= frame_q + 1'b1;
                        state_q   <= ST_RESTART;
                    end else begin
                        band_q <= band_q + 1'b1;
                    end
                end
                ST_RESTART: begin
                    restart_q <= 1'b0;
                    band_q    <= '0;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    band_max_tracker #(.AW(FFT_N), .MW(MW)) u_trk (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .upd_i (v2_q),
        .bin_i (a2_q),
        .mag_i (mag_q),
        .sel_i (band_q),
        .bin_o (trk_bin),
        .mag_o (trk_mag)
    );

    assign bus.dmaact     = act_q;
    assign bus.dmaa       = addr_q;
    assign bus.peak_valid = valid_q;
    assign bus.peak_band  = valid_q ? band_q : '0;
    assign bus.peak_bin   = valid_q ? trk_bin : '0;
    assign bus.peak_mag   = valid_q ? trk_mag : '0;
    assign bus.peak_exp   = valid_q ? exp_q : '0;
    assign fft_restart    = restart_q;
    assign frame_count    = frame_q;
endmodule

// File: tb/tb_spectrum_peak_picker.sv
// tb_spectrum_peak_picker: directed + random frames checked against a per-band max reference model.
module tb_spectrum_peak_picker;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fft_done = 1'b0;
    logic signed [7:0] fft_bfpexp = '0;
    logic              fft_restart;
    logic [15:0]       frame_count;

    spectrum_peak_picker_if #(.FFT_N(10), .DATA_WIDTH(16)) bus ();

    spectrum_peak_picker #(.FFT_N(10), .DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .fft_done    (fft_done),
        .fft_bfpexp  (fft_bfpexp),
        .fft_restart (fft_restart),
        .frame_count (frame_count),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int lo [6] = '{1, 11, 21, 41, 81, 161};
    int hi [6] = '{10, 20, 40, 80, 160, 511};
    int re_m [512];
    int im_m [512];
    int total = 0;
    int bad = 0;
    int restarts = 0;
    int frames = 0;

    // FFT memory: synchronous read, junk on the bus when not reading.
    always @(posedge clk) begin
        bus.dmadr_real <= bus.dmaact ? 16'(re_m[bus.dmaa]) : 16'($urandom);
        bus.dmadr_imag <= bus.dmaact ? 16'(im_m[bus.dmaa]) : 16'($urandom);
        if (fft_restart === 1'b1) restarts++;
    end

    function automatic longint mag_of(input int re, input int im);
`ifdef SPECTRUM_L1_MAG_EN
        return longint'(re < 0 ? -re : re) + longint'(im < 0 ? -im : im);
`else
        return longint'(re) * re + longint'(im) * im;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 512; k++) begin
            re_m[k] = 0;
            im_m[k] = 0;
        end
    endtask

    task automatic random_mem();
        for (int k = 0; k < 512; k++) begin
            re_m[k] = int'($urandom_range(0, 65535)) - 32768;
            im_m[k] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic run_frame(input int e, input int stall_band, input int stall_len);
        longint em [6];
        int     eb [6];
        int     lat, act_n;
        bit     seq_ok;
        for (int b = 0; b < 6; b++) begin
            eb[b] = lo[b];
            em[b] = 0;
            for (int k = lo[b]; k <= hi[b]; k++)
                if (mag_of(re_m[k], im_m[k]) > em[b]) begin
                    em[b] = mag_of(re_m[k], im_m[k]);
                    eb[b] = k;
                end
        end
        @(negedge clk);
        fft_done = 1'b1;
        fft_bfpexp = 8'(e);
        lat = 0;
        act_n = 0;
        seq_ok = 1'b1;
        while (lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.peak_valid === 1'b1) break;
            if (bus.dmaact === 1'b1) begin
                act_n++;
                if (bus.dmaa !== 10'(act_n)) seq_ok = 1'b0;
            end
        end
        chk("latency", 64'(lat), 64'd514);
        chk("scan_len", 64'(act_n), 64'd511);
        chk("scan_seq", 64'(seq_ok), 64'd1);
        frames++;
        for (int b = 0; b < 6; b++) begin
            chk("valid", 64'(bus.peak_valid), 64'd1);
            chk("band", 64'(bus.peak_band), 64'(b));
            chk("bin", 64'(bus.peak_bin), 64'(eb[b]));
            chk("mag", 64'(bus.peak_mag), 64'(em[b]));
            chk("exp", {56'd0, bus.peak_exp}, {56'd0, 8'(e)});
            if (b == stall_band)
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                    chk("hold_valid", 64'(bus.peak_valid), 64'd1);
                    chk("hold_band", 64'(bus.peak_band), 64'(b));
                    chk("hold_bin", 64'(bus.peak_bin), 64'(eb[b]));
                    chk("hold_mag", 64'(bus.peak_mag), 64'(em[b]));
                    chk("hold_no_restart", 64'(fft_restart), 64'd0);
                end
            bus.peak_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.peak_ready = 1'b0;
        end
        chk("restart_pulse", 64'(fft_restart), 64'd1);
        chk("valid_after", 64'(bus.peak_valid), 64'd0);
        chk("frame_count", 64'(frame_count), 64'(frames));
        fft_done = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_once", 64'(fft_restart), 64'd0);
    endtask

    initial begin
        bus.peak_ready = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dmaact", 64'(bus.dmaact), 64'd0);
        chk("rst_dmaa", 64'(bus.dmaa), 64'd0);
        chk("rst_valid", 64'(bus.peak_valid), 64'd0);
        chk("rst_band", 64'(bus.peak_band), 64'd0);
        chk("rst_bin", 64'(bus.peak_bin), 64'd0);
        chk("rst_mag", 64'(bus.peak_mag), 64'd0);
        chk("rst_exp", {56'd0, bus.peak_exp}, 64'd0);
        chk("rst_restart", 64'(fft_restart), 64'd0);
        chk("rst_frames", 64'(frame_count), 64'd0);
        rst = 1'b0;

        // Abort a scan with strong random data, then make sure none of it survives.
        random_mem();
        @(negedge clk);
        fft_done = 1'b1;
        fft_bfpexp = 8'sd7;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (bus.dmaact === 1'b1 && bus.dmaa === 10'd100) break;
        end
        chk("reach_addr100", 64'(bus.dmaa), 64'd100);
        rst = 1'b1;
        fft_done = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_dmaact", 64'(bus.dmaact), 64'd0);
        chk("midrst_dmaa", 64'(bus.dmaa), 64'd0);
        chk("midrst_valid", 64'(bus.peak_valid), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold", 64'(bus.dmaact), 64'd0);

        clear_mem();
        re_m[37] = 1000;
        run_frame(2, -1, 0);

        clear_mem();
        re_m[12] = 300;
        im_m[12] = 400;
        re_m[15] = 300;
        im_m[15] = 400;
        run_frame(-1, 3, 20);

        clear_mem();
        re_m[200] = -32768;
        im_m[200] = -32768;
        run_frame(5, -1, 0);
        chk("frames_after_three", 64'(frame_count), 64'd3);

        random_mem();
        run_frame(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 5)), int'($urandom_range(1, 8)));
        chk("restart_total", 64'(restarts), 64'(frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
